assoc_memory_param: RTL and testbench
=====================================

ASSOC_MEMORY_PARAM -- requirements
Module: assoc_memory_param

Interface
REQ-001 SHALL have parameter HV_DIM, default 2000, hypervector width in bits.
REQ-002 SHALL have parameter FOLD_WIDTH, default 200, bits compared per cycle.
REQ-003 SHALL have parameter NUM_CLASSES, default 4 (range 2..16), number of stored prototypes.
REQ-004 SHALL derive NUM_FOLDS = ceil(HV_DIM/FOLD_WIDTH), CLASS_W = max(1,clog2(NUM_CLASSES)), FOLD_W = max(1,clog2(NUM_FOLDS)), DIST_W = clog2(HV_DIM+1).
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-006 clk  in  1  clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 proto_we / proto_ready  in/out  1/1  prototype write strobe and acceptance.
REQ-009 proto_class / proto_fold / proto_wdata  in  CLASS_W / FOLD_W / FOLD_WIDTH  write address and data.
REQ-010 hvin_valid / hvin_ready  in/out  1/1  query handshake.
REQ-011 hvin  in  HV_DIM  query hypervector.
REQ-012 dout_valid / dout_ready  out/in  1/1  result handshake.
REQ-013 dout_class  out  CLASS_W  index of nearest prototype.
REQ-014 dout_distance  out  DIST_W  Hamming distance of winner (present only under AM_DISTANCE_OUT_EN).

Function
REQ-015 SHALL store NUM_CLASSES x NUM_FOLDS prototype words of FOLD_WIDTH bits in flops.
REQ-016 SHALL implement FSM IDLE -> COMPUTE on hvin fire; COMPUTE -> DONE after the last fold of the last class; DONE -> IDLE on dout fire.
REQ-017 proto_ready SHALL be 1 only in IDLE; a write occurs when proto_we && proto_ready; writes with proto_class >= NUM_CLASSES or proto_fold >= NUM_FOLDS are ignored.
REQ-018 hvin_ready SHALL equal (state==IDLE) && !proto_we; a simultaneous write takes priority over a query.
REQ-019 On hvin fire, SHALL register hvin internally; hvin may change afterwards without affecting the result.
REQ-020 In COMPUTE, SHALL process one fold of one class per cycle, class-major, fold-minor, popcounting XOR of query fold and prototype fold.
REQ-021 Bits of the final fold at positions >= HV_DIM SHALL be masked to 0 before popcount.
REQ-022 SHALL accumulate per-class distance in DIST_W bits, with no overflow possible by construction.
REQ-023 After each class's last fold, SHALL replace the best (distance,class) only if the new distance is strictly less; ties keep the lower class index; class 0 always initialises best.
REQ-024 dout_valid SHALL rise exactly NUM_CLASSES*NUM_FOLDS cycles after the hvin-fire edge and SHALL hold with stable outputs until dout_ready.
REQ-025 hvin_ready SHALL be re-asserted the cycle after dout fire (no overlap of queries).
REQ-026 dout_class SHALL hold its last value outside DONE.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, dout_valid=0, dout_class=0, dout_distance=0, accumulators=0, all prototype words=0.
REQ-028 Reset asserted mid-COMPUTE or in DONE SHALL abort the query with no result emitted.

Configuration
REQ-029 Macro AM_DISTANCE_OUT_EN defined: dout_distance port exists and carries the winning distance while dout_valid=1.
REQ-030 Macro AM_DISTANCE_OUT_EN undefined: the dout_distance port and its output register are absent; dout_class behaviour is identical.

Verification
REQ-031 HV_DIM=10, FOLD_WIDTH=4, NUM_CLASSES=4: load class k = all ones in its k lowest bits; query 10'b0000000111 -> dout_class=3, distance=0, dout_valid 12 cycles after fire.
REQ-032 Tie: classes 1 and 2 both at distance 3 from the query, others farther -> dout_class=1, distance=3.
REQ-033 Partial fold: prototype padding bits set via a full 4-bit write to fold 2 -> those bits are excluded from the distance (query all zeros, class 0 fold2 = 4'b1111 -> distance 2).
REQ-034 Backpressure: hold dout_ready=0 for 20 cycles -> dout_valid, dout_class stable; hvin_ready=0 throughout; proto_we is ignored.
REQ-035 Defaults (2000/200/4): rst_n pulsed low at cycle 17 of COMPUTE -> no dout_valid; the next query completes in 40 cycles with the correct result.
REQ-036 proto_we and hvin_valid asserted together in IDLE -> the write lands; hvin_ready=0 that cycle; the query is accepted the following cycle and uses the new prototype.

Source files
------------

// File: rtl/assoc_memory_param.sv
// assoc_memory_param
// Folded associative memory for hyperdimensional classification. It holds
// NUM_CLASSES prototype hypervectors in flops, each split into NUM_FOLDS words
// of FOLD_WIDTH bits. A query is compared one fold per cycle against every
// prototype. The index of the prototype with the smallest Hamming distance is
// returned; on equal distances the lower index wins.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   proto_we / proto_ready       prototype write strobe / accepted (IDLE only)
//   proto_class / proto_fold     prototype write address (out-of-range ignored)
//   proto_wdata                  prototype fold data
//   hvin_valid / hvin_ready      query handshake
//   hvin                         query hypervector
//   dout_valid / dout_ready      result handshake
//   dout_class                   index of the nearest prototype
//   dout_distance                winning Hamming distance (AM_DISTANCE_OUT_EN only)
//
// Optional feature macro: AM_DISTANCE_OUT_EN adds the dout_distance port.
module assoc_memory_param #(
  parameter int HV_DIM      = 2000,
  parameter int FOLD_WIDTH  = 200,
  parameter int NUM_CLASSES = 4,
  localparam int NUM_FOLDS  = (HV_DIM + FOLD_WIDTH - 1) / FOLD_WIDTH,
  localparam int CLASS_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int FOLD_W     = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1,
  localparam int DIST_W     = $clog2(HV_DIM + 1),
  localparam int PAD_W      = NUM_FOLDS * FOLD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proto_we,
  output logic                  proto_ready,
  input  logic [CLASS_W-1:0]    proto_class,
  input  logic [FOLD_W-1:0]     proto_fold,
  input  logic [FOLD_WIDTH-1:0] proto_wdata,
  input  logic                  hvin_valid,
  output logic                  hvin_ready,
  input  logic [HV_DIM-1:0]     hvin,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [CLASS_W-1:0]    dout_class
`ifdef AM_DISTANCE_OUT_EN
  ,
  output logic [DIST_W-1:0]     dout_distance
`endif
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e state_q, state_d;

  logic [FOLD_WIDTH-1:0] protoMem_q [NUM_CLASSES][NUM_FOLDS];
  logic [FOLD_WIDTH-1:0] queryMem_q [NUM_FOLDS];
  logic [CLASS_W-1:0]    classIdx_q;
  logic [FOLD_W-1:0]     foldIdx_q;
  logic [DIST_W-1:0]     acc_q;
  logic [DIST_W-1:0]     bestDist_q;
  logic [CLASS_W-1:0]    bestClass_q;
  logic [CLASS_W-1:0]    doutClass_q;
`ifdef AM_DISTANCE_OUT_EN
  logic [DIST_W-1:0]     doutDist_q;
`endif

  logic                  hvinFire;
  logic                  protoWrite;
  logic                  lastFold;
  logic                  lastClass;
  logic [PAD_W-1:0]      hvinPadded;
  logic [FOLD_WIDTH-1:0] foldMask;
  logic [FOLD_WIDTH-1:0] foldDiff;
  logic [DIST_W-1:0]     foldCount;
  logic [DIST_W-1:0]     classDist;
  logic                  takeNew;
  logic [CLASS_W-1:0]    winClass;
  logic [DIST_W-1:0]     winDist;

  // Next-state logic and handshake outputs. A pending prototype write blocks
  // query acceptance for that cycle, so a write always lands first.
  always_comb begin
    state_d     = state_q;
    proto_ready = 1'b0;
    hvin_ready  = 1'b0;
    dout_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        proto_ready = 1'b1;
        hvin_ready  = !proto_we;
        if (hvin_valid && !proto_we) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (lastFold && lastClass) state_d = DONE;
      end
      DONE: begin
        dout_valid = 1'b1;
        if (dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign hvinFire   = hvin_valid && hvin_ready;
  assign protoWrite = proto_we && proto_ready
                      && (int'(proto_class) < NUM_CLASSES)
                      && (int'(proto_fold) < NUM_FOLDS);
  assign lastFold   = (int'(foldIdx_q) == NUM_FOLDS - 1);
  assign lastClass  = (int'(classIdx_q) == NUM_CLASSES - 1);

  // Query widened to a whole number of folds; the padding is zero.
  always_comb begin
    hvinPadded = '0;
    hvinPadded[HV_DIM-1:0] = hvin;
  end

  // Prototype padding bits beyond HV_DIM can be written, so they are masked
  // out here rather than relying on the stored prototype being clean.
  always_comb begin
    foldMask = '0;
    for (int b = 0; b < FOLD_WIDTH; b++) begin
      foldMask[b] = ((int'(foldIdx_q) * FOLD_WIDTH + b) < HV_DIM);
    end
  end

  assign foldDiff = (queryMem_q[foldIdx_q] ^ protoMem_q[classIdx_q][foldIdx_q]) & foldMask;

  always_comb begin
    foldCount = '0;
    for (int b = 0; b < FOLD_WIDTH; b++) begin
      foldCount = foldCount + DIST_W'(foldDiff[b]);
    end
  end

  // At most HV_DIM bits ever differ per class, so DIST_W cannot overflow.
  assign classDist = acc_q + foldCount;
  assign takeNew   = (classIdx_q == '0) || (classDist < bestDist_q);
  assign winClass  = takeNew ? classIdx_q : bestClass_q;
  assign winDist   = takeNew ? classDist : bestDist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int f = 0; f < NUM_FOLDS; f++) begin
          protoMem_q[c][f] <= '0;
        end
      end
    end else if (protoWrite) begin
      protoMem_q[proto_class][proto_fold] <= proto_wdata;
    end
  end

  // Class-major, fold-minor sweep. The best candidate is updated after each
  // class's last fold; the final winner goes straight to the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      classIdx_q  <= '0;
      foldIdx_q   <= '0;
      acc_q       <= '0;
      bestDist_q  <= '0;
      bestClass_q <= '0;
      doutClass_q <= '0;
`ifdef AM_DISTANCE_OUT_EN
      doutDist_q  <= '0;
`endif
      for (int f = 0; f < NUM_FOLDS; f++) queryMem_q[f] <= '0;
    end else if (hvinFire) begin
      classIdx_q <= '0;
      foldIdx_q  <= '0;
      acc_q      <= '0;
      for (int f = 0; f < NUM_FOLDS; f++) begin
        queryMem_q[f] <= hvinPadded[f*FOLD_WIDTH +: FOLD_WIDTH];
      end
    end else if (state_q == COMPUTE) begin
      if (lastFold) begin
        foldIdx_q   <= '0;
        acc_q       <= '0;
        bestClass_q <= winClass;
        bestDist_q  <= winDist;
        classIdx_q  <= lastClass ? '0 : classIdx_q + CLASS_W'(1);
        if (lastClass) begin
          doutClass_q <= winClass;
`ifdef AM_DISTANCE_OUT_EN
          doutDist_q  <= winDist;
`endif
        end
      end else begin
        foldIdx_q <= foldIdx_q + FOLD_W'(1);
        acc_q     <= classDist;
      end
    end
  end

  assign dout_class = doutClass_q;
`ifdef AM_DISTANCE_OUT_EN
  assign dout_distance = doutDist_q;
`endif

endmodule

// File: tb/tb_assoc_memory_param.sv
// tb_assoc_memory_param
// Self-checking bench for assoc_memory_param. The small instance has
// HV_DIM=10, FOLD_WIDTH=4 and NUM_CLASSES=4. The default instance has
// 2000/200/4 and is used for the mid-compute reset case.
// Distance checks are active when AM_DISTANCE_OUT_EN is defined.
module tb_assoc_memory_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance signals
  logic        sRstN, sProtoWe, sProtoReady;
  logic [1:0]  sProtoClass, sProtoFold;
  logic [3:0]  sProtoWdata;
  logic        sHvinValid, sHvinReady;
  logic [9:0]  sHvin;
  logic        sDoutValid, sDoutReady;
  logic [1:0]  sDoutClass;
`ifdef AM_DISTANCE_OUT_EN
  logic [3:0]  sDoutDistance;
`endif

  // Default-size instance signals
  logic           lRstN, lProtoWe, lProtoReady;
  logic [1:0]     lProtoClass;
  logic [3:0]     lProtoFold;
  logic [199:0]   lProtoWdata;
  logic           lHvinValid, lHvinReady;
  logic [1999:0]  lHvin;
  logic           lDoutValid, lDoutReady;
  logic [1:0]     lDoutClass;
`ifdef AM_DISTANCE_OUT_EN
  logic [10:0]    lDoutDistance;
`endif

  assoc_memory_param #(.HV_DIM(10), .FOLD_WIDTH(4), .NUM_CLASSES(4)) dutSmall (
    .clk(clk), .rst_n(sRstN),
    .proto_we(sProtoWe), .proto_ready(sProtoReady),
    .proto_class(sProtoClass), .proto_fold(sProtoFold), .proto_wdata(sProtoWdata),
    .hvin_valid(sHvinValid), .hvin_ready(sHvinReady), .hvin(sHvin),
    .dout_valid(sDoutValid), .dout_ready(sDoutReady), .dout_class(sDoutClass)
`ifdef AM_DISTANCE_OUT_EN
    , .dout_distance(sDoutDistance)
`endif
  );

  assoc_memory_param #(.HV_DIM(2000), .FOLD_WIDTH(200), .NUM_CLASSES(4)) dutLarge (
    .clk(clk), .rst_n(lRstN),
    .proto_we(lProtoWe), .proto_ready(lProtoReady),
    .proto_class(lProtoClass), .proto_fold(lProtoFold), .proto_wdata(lProtoWdata),
    .hvin_valid(lHvinValid), .hvin_ready(lHvinReady), .hvin(lHvin),
    .dout_valid(lDoutValid), .dout_ready(lDoutReady), .dout_class(lDoutClass)
`ifdef AM_DISTANCE_OUT_EN
    , .dout_distance(lDoutDistance)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;

  int    sbClass[$];
  int    sbDist[$];
  string sbTag[$];
  int    monClass, monDist;
  string monTag;

  typedef struct {
    logic [9:0] query;
    int         expClass;
    int         expDist;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Output side of the scoreboard: pop one expectation per dout handshake
  always @(negedge clk) begin
    if (sRstN && sDoutValid && sDoutReady) begin
      if (sbClass.size() == 0) begin
        checkOutput("unexpected dout", 1, 0);
      end else begin
        monClass = sbClass.pop_front();
        monDist  = sbDist.pop_front();
        monTag   = sbTag.pop_front();
        checkOutput({monTag, " class"}, int'(sDoutClass), monClass);
`ifdef AM_DISTANCE_OUT_EN
        checkOutput({monTag, " distance"}, int'(sDoutDistance), monDist);
`endif
      end
    end
  end

  task automatic writeFold(input int cls, input int fold, input logic [3:0] data);
    @(posedge clk); #1;
    sProtoWe = 1'b1; sProtoClass = 2'(cls); sProtoFold = 2'(fold); sProtoWdata = data;
    @(posedge clk); #1;
    sProtoWe = 1'b0;
  endtask

  task automatic loadClass(input int cls, input logic [9:0] v);
    writeFold(cls, 0, v[3:0]);
    writeFold(cls, 1, v[7:4]);
    writeFold(cls, 2, {2'b00, v[9:8]});
  endtask

  // Called one step after the fire edge: measures latency, then completes
  // the output handshake if the sink is ready.
  task automatic waitDoneS(input string tag);
    int lat = 0;
    while (!sDoutValid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 12);
    if (sDoutReady) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic [9:0] q, input int expCls, input int expDist,
                               input string tag);
    logic accepted = 1'b0;
    sbClass.push_back(expCls); sbDist.push_back(expDist); sbTag.push_back(tag);
    @(posedge clk); #1;
    sHvin = q; sHvinValid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk); accepted = sHvinReady;
      @(posedge clk); #1;
    end
    sHvinValid = 1'b0;
    sHvin = 10'($urandom);
    if (!accepted) checkOutput({tag, " accepted"}, 0, 1);
    else waitDoneS(tag);
  endtask

  task automatic writeFoldL(input int cls, input int fold, input logic [199:0] data);
    @(posedge clk); #1;
    lProtoWe = 1'b1; lProtoClass = 2'(cls); lProtoFold = 4'(fold); lProtoWdata = data;
    @(posedge clk); #1;
    lProtoWe = 1'b0;
  endtask

  task automatic applyStimulusL(input logic [1999:0] q, input int expCls, input int expDist,
                                input string tag);
    logic accepted = 1'b0;
    int lat = 0;
    @(posedge clk); #1;
    lHvin = q; lHvinValid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk); accepted = lHvinReady;
      @(posedge clk); #1;
    end
    lHvinValid = 1'b0;
    lHvin = ~q;
    checkOutput({tag, " accepted"}, int'(accepted), 1);
    while (!lDoutValid && lat < 500) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 40);
    checkOutput({tag, " class"}, int'(lDoutClass), expCls);
`ifdef AM_DISTANCE_OUT_EN
    checkOutput({tag, " distance"}, int'(lDoutDistance), expDist);
`else
    if (expDist < 0) checkOutput({tag, " bad expected distance"}, expDist, 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]    heldClass;
    logic          sawValid;
    logic [1999:0] qL;

    vecs[0] = '{10'h007, 3, 0};
    vecs[1] = '{10'h000, 0, 0};
    vecs[2] = '{10'h001, 1, 0};
    vecs[3] = '{10'h003, 2, 0};
    vecs[4] = '{10'h3FF, 3, 7};
    vecs[5] = '{10'h002, 0, 1};

    sRstN = 1'b0; sProtoWe = 1'b0; sProtoClass = '0; sProtoFold = '0; sProtoWdata = '0;
    sHvinValid = 1'b0; sHvin = '0; sDoutReady = 1'b1;
    lRstN = 1'b0; lProtoWe = 1'b0; lProtoClass = '0; lProtoFold = '0; lProtoWdata = '0;
    lHvinValid = 1'b0; lHvin = '0; lDoutReady = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset dout_valid", int'(sDoutValid), 0);
    checkOutput("reset dout_class", int'(sDoutClass), 0);
    checkOutput("reset proto_ready", int'(sProtoReady), 1);
    checkOutput("reset hvin_ready", int'(sHvinReady), 1);
`ifdef AM_DISTANCE_OUT_EN
    checkOutput("reset dout_distance", int'(sDoutDistance), 0);
`endif
    checkOutput("reset large dout_valid", int'(lDoutValid), 0);
    @(posedge clk); #1;
    sRstN = 1'b1; lRstN = 1'b1;

    // Class k holds ones in its k lowest bits
    loadClass(0, 10'h000);
    loadClass(1, 10'h001);
    loadClass(2, 10'h003);
    loadClass(3, 10'h007);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].query, vecs[i].expClass, vecs[i].expDist, $sformatf("vec%0d", i));
    end

    // Tie at distance 3 between classes 1 and 2
    loadClass(0, 10'h01F);
    loadClass(1, 10'h007);
    loadClass(2, 10'h038);
    loadClass(3, 10'h0FF);
    applyStimulus(10'h000, 1, 3, "tie");

    // Padding bits of the last fold written as ones must not count
    loadClass(0, 10'h000);
    writeFold(0, 2, 4'b1111);
    loadClass(1, 10'h007);
    loadClass(2, 10'h0FF);
    loadClass(3, 10'h3FF);
    applyStimulus(10'h000, 0, 2, "partial fold");

    // Backpressure: result held, queries and writes locked out
    @(posedge clk); #1;
    sDoutReady = 1'b0;
    applyStimulus(10'h3FF, 3, 0, "backpressure");
    heldClass = sDoutClass;
    checkOutput("bp held class", int'(heldClass), 3);
    sProtoWe = 1'b1; sProtoClass = 2'd2; sProtoFold = 2'd1; sProtoWdata = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("bp dout_valid", int'(sDoutValid), 1);
      checkOutput("bp dout_class stable", int'(sDoutClass), int'(heldClass));
      checkOutput("bp hvin_ready", int'(sHvinReady), 0);
      checkOutput("bp proto_ready", int'(sProtoReady), 0);
    end
    @(posedge clk); #1;
    sProtoWe = 1'b0; sDoutReady = 1'b1;
    @(posedge clk); #1;
    applyStimulus(10'h0F0, 2, 4, "bp write ignored");

    // Simultaneous write and query: write first, query uses the new word
    loadClass(0, 10'h000);
    loadClass(1, 10'h001);
    loadClass(2, 10'h003);
    loadClass(3, 10'h007);
    @(posedge clk); #1;
    sbClass.push_back(2); sbDist.push_back(4); sbTag.push_back("simul");
    sProtoWe = 1'b1; sProtoClass = 2'd2; sProtoFold = 2'd1; sProtoWdata = 4'hF;
    sHvin = 10'h3F0; sHvinValid = 1'b1;
    @(negedge clk);
    checkOutput("simul hvin_ready blocked", int'(sHvinReady), 0);
    checkOutput("simul proto_ready", int'(sProtoReady), 1);
    @(posedge clk); #1;
    sProtoWe = 1'b0;
    @(negedge clk);
    checkOutput("simul hvin_ready next", int'(sHvinReady), 1);
    @(posedge clk); #1;
    sHvinValid = 1'b0; sHvin = 10'($urandom);
    waitDoneS("simul");

    // Default size: reset in the 17th COMPUTE cycle aborts the query
    for (int f = 0; f < 10; f++) writeFoldL(3, f, '1);
    @(posedge clk); #1;
    lHvin = '1; lHvinValid = 1'b1;
    @(negedge clk);
    checkOutput("abort query accepted", int'(lHvinReady), 1);
    @(posedge clk); #1;
    lHvinValid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    lRstN = 1'b0;
    @(negedge clk);
    checkOutput("abort dout_valid in reset", int'(lDoutValid), 0);
    @(posedge clk); #1;
    lRstN = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lDoutValid) sawValid = 1'b1;
    end
    checkOutput("abort no dout_valid", int'(sawValid), 0);
    checkOutput("abort back to idle", int'(lHvinReady), 1);

    // Reset cleared every prototype: all classes tie at 2000, class 0 wins
    applyStimulusL('1, 0, 2000, "post-reset");
    for (int f = 0; f < 10; f++) writeFoldL(3, f, '1);
    qL = '1;
    qL[99:0] = '0;
    applyStimulusL(qL, 3, 100, "large query");

    checkOutput("scoreboard drained", sbClass.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
